// File: rtl/eth_stats_if.sv
// eth_stats_if: MAC status stream in, live and snapshot statistics out
// master drives enable/valid/frame_length/frame_good/snap_req/snap_clear and reads the counters.
// slave is the accumulator side.
interface eth_stats_if #(
  parameter int COUNTER_WIDTH = 64,
  parameter int LENGTH_WIDTH = 17
);
  logic enable;
  logic valid;
  logic [LENGTH_WIDTH-1:0] frame_length;
  logic frame_good;
  logic snap_req;
  logic snap_clear;
  logic [COUNTER_WIDTH-1:0] total_bytes;
  logic [COUNTER_WIDTH-1:0] total_good;
  logic [COUNTER_WIDTH-1:0] total_bad;
  logic [2:0] overflow;
  logic [COUNTER_WIDTH-1:0] snap_bytes;
  logic [COUNTER_WIDTH-1:0] snap_good;
  logic [COUNTER_WIDTH-1:0] snap_bad;
  logic [2:0] snap_overflow;
  logic snap_valid;
  modport master (
    output enable, valid, frame_length, frame_good, snap_req, snap_clear,
    input total_bytes, total_good, total_bad, overflow,
    input snap_bytes, snap_good, snap_bad, snap_overflow, snap_valid
  );
  modport slave (
    input enable, valid, frame_length, frame_good, snap_req, snap_clear,
    output total_bytes, total_good, total_bad, overflow,
    output snap_bytes, snap_good, snap_bad, snap_overflow, snap_valid
  );
endinterface

// File: rtl/eth_stats_accumulator.sv
// eth_stats_accumulator: per-port byte/good/bad frame counters with wrap or saturate and atomic snapshot
// clk, rst : clock and synchronous active-high reset
// s        : eth_stats_if slave; widths must match COUNTER_WIDTH / LENGTH_WIDTH
module eth_stats_accumulator #(
  parameter int COUNTER_WIDTH = 64,
  parameter int LENGTH_WIDTH = 17,
  parameter bit SATURATE = 1'b0
) (
  input logic clk,
  input logic rst,
  eth_stats_if.slave s
);
  localparam int CW = COUNTER_WIDTH;
  logic s1_v, s1_good;
  logic [LENGTH_WIDTH-1:0] s1_len;
  logic [CW-1:0] total_bytes, total_good, total_bad;
  logic [CW-1:0] snap_bytes, snap_good, snap_bad;
  logic [2:0] overflow, snap_overflow;
  logic snap_valid;
  logic [CW:0] sum_b, sum_g, sum_r;
  logic [CW-1:0] n_bytes, n_good, n_bad;
  logic [2:0] n_ovf;
  // Values the live registers take this edge before any clear; snapshots load these too.
  always_comb begin
    sum_b = {1'b0, total_bytes} + (s1_v ? {{(CW+1-LENGTH_WIDTH){1'b0}}, s1_len} : '0);
    sum_g = {1'b0, total_good} + (CW+1)'(s1_v & s1_good);
    sum_r = {1'b0, total_bad} + (CW+1)'(s1_v & ~s1_good);
    n_bytes = (SATURATE && sum_b[CW]) ? '1 : sum_b[CW-1:0];
    n_good = (SATURATE && sum_g[CW]) ? '1 : sum_g[CW-1:0];
    n_bad = (SATURATE && sum_r[CW]) ? '1 : sum_r[CW-1:0];
    n_ovf = overflow | {sum_r[CW], sum_g[CW], sum_b[CW]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s1_len <= '0;
      s1_good <= 1'b0;
      total_bytes <= '0;
      total_good <= '0;
      total_bad <= '0;
      overflow <= '0;
      snap_bytes <= '0;
      snap_good <= '0;
      snap_bad <= '0;
      snap_overflow <= '0;
      snap_valid <= 1'b0;
    end else begin
      s1_v <= s.valid & s.enable;
      if (s.valid & s.enable) begin
        s1_len <= s.frame_length;
        s1_good <= s.frame_good;
      end
      snap_valid <= s.snap_req;
      if (s.snap_req) begin
        snap_bytes <= n_bytes;
        snap_good <= n_good;
        snap_bad <= n_bad;
        snap_overflow <= n_ovf;
      end
      total_bytes <= (s.snap_req & s.snap_clear) ? '0 : n_bytes;
      total_good <= (s.snap_req & s.snap_clear) ? '0 : n_good;
      total_bad <= (s.snap_req & s.snap_clear) ? '0 : n_bad;
      overflow <= (s.snap_req & s.snap_clear) ? '0 : n_ovf;
    end
  end
  assign s.total_bytes = total_bytes;
  assign s.total_good = total_good;
  assign s.total_bad = total_bad;
  assign s.overflow = overflow;
  assign s.snap_bytes = snap_bytes;
  assign s.snap_good = snap_good;
  assign s.snap_bad = snap_bad;
  assign s.snap_overflow = snap_overflow;
  assign s.snap_valid = snap_valid;
endmodule

// File: tb/tb_eth_stats_accumulator.sv
// tb_eth_stats_accumulator: table, directed and random checks of three accumulator configurations
module tb_eth_stats_accumulator;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, valid, enable, good, snap_req, snap_clear;
  logic [16:0] len;
  int n_chk = 0;
  int n_fail = 0;
  eth_stats_if #(.COUNTER_WIDTH(64), .LENGTH_WIDTH(17)) b0 ();
  eth_stats_if #(.COUNTER_WIDTH(8), .LENGTH_WIDTH(8)) b1 ();
  eth_stats_if #(.COUNTER_WIDTH(8), .LENGTH_WIDTH(8)) b2 ();
  assign b0.valid = valid;
  assign b0.enable = enable;
  assign b0.frame_length = len;
  assign b0.frame_good = good;
  assign b0.snap_req = snap_req;
  assign b0.snap_clear = snap_clear;
  assign b1.valid = valid;
  assign b1.enable = enable;
  assign b1.frame_length = len[7:0];
  assign b1.frame_good = good;
  assign b1.snap_req = snap_req;
  assign b1.snap_clear = snap_clear;
  assign b2.valid = valid;
  assign b2.enable = enable;
  assign b2.frame_length = len[7:0];
  assign b2.frame_good = good;
  assign b2.snap_req = snap_req;
  assign b2.snap_clear = snap_clear;
  eth_stats_accumulator #(.COUNTER_WIDTH(64), .LENGTH_WIDTH(17), .SATURATE(1'b0)) dut0 (.clk(clk), .rst(rst), .s(b0));
  eth_stats_accumulator #(.COUNTER_WIDTH(8), .LENGTH_WIDTH(8), .SATURATE(1'b0)) dut1 (.clk(clk), .rst(rst), .s(b1));
  eth_stats_accumulator #(.COUNTER_WIDTH(8), .LENGTH_WIDTH(8), .SATURATE(1'b1)) dut2 (.clk(clk), .rst(rst), .s(b2));
  typedef struct {
    logic [63:0] b, g, r, sb, sg, sr;
    logic [2:0] o, so;
    logic sv;
  } obs_t;
  function automatic obs_t get(int i);
    obs_t x;
    if (i == 0) begin
      x.b = b0.total_bytes; x.g = b0.total_good; x.r = b0.total_bad; x.o = b0.overflow;
      x.sb = b0.snap_bytes; x.sg = b0.snap_good; x.sr = b0.snap_bad; x.so = b0.snap_overflow; x.sv = b0.snap_valid;
    end else if (i == 1) begin
      x.b = 64'(b1.total_bytes); x.g = 64'(b1.total_good); x.r = 64'(b1.total_bad); x.o = b1.overflow;
      x.sb = 64'(b1.snap_bytes); x.sg = 64'(b1.snap_good); x.sr = 64'(b1.snap_bad); x.so = b1.snap_overflow; x.sv = b1.snap_valid;
    end else begin
      x.b = 64'(b2.total_bytes); x.g = 64'(b2.total_good); x.r = 64'(b2.total_bad); x.o = b2.overflow;
      x.sb = 64'(b2.snap_bytes); x.sg = 64'(b2.snap_good); x.sr = 64'(b2.snap_bad); x.so = b2.snap_overflow; x.sv = b2.snap_valid;
    end
    return x;
  endfunction
  int cw[3] = '{64, 8, 8};
  int lw[3] = '{17, 8, 8};
  bit sat[3] = '{1'b0, 1'b0, 1'b1};
  logic [63:0] m_tot[3][3];
  logic [63:0] m_snap[3][3];
  logic [2:0] m_ov[3];
  logic [2:0] m_sov[3];
  logic m_sv[3];
  logic p_v, p_good;
  logic [16:0] p_len;
  task automatic chk(input string name, input int i, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, i, act, exp, $time);
    end
  endtask
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        for (int k = 0; k < 3; k++) begin
          m_tot[i][k] = '0;
          m_snap[i][k] = '0;
        end
        m_ov[i] = '0;
        m_sov[i] = '0;
        m_sv[i] = 1'b0;
      end else begin
        logic [63:0] nt[3];
        logic [2:0] no;
        logic [64:0] mx, inc, sm;
        mx = (65'd1 << cw[i]) - 65'd1;
        no = m_ov[i];
        for (int k = 0; k < 3; k++) begin
          if (!p_v) inc = 0;
          else if (k == 0) inc = 65'(p_len) & ((65'd1 << lw[i]) - 65'd1);
          else inc = 65'((k == 1) == p_good);
          sm = 65'(m_tot[i][k]) + inc;
          if (sm > mx) no[k] = 1'b1;
          nt[k] = (sm > mx) ? (sat[i] ? mx[63:0] : 64'(sm & mx)) : sm[63:0];
        end
        m_sv[i] = snap_req;
        if (snap_req) begin
          for (int k = 0; k < 3; k++) m_snap[i][k] = nt[k];
          m_sov[i] = no;
        end
        for (int k = 0; k < 3; k++) m_tot[i][k] = (snap_req && snap_clear) ? 64'd0 : nt[k];
        m_ov[i] = (snap_req && snap_clear) ? 3'd0 : no;
      end
    end
    p_v = !rst && valid && enable;
    if (valid && enable) begin
      p_len = len;
      p_good = good;
    end
  endtask
  task automatic step();
    obs_t x;
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 3; i++) begin
      x = get(i);
      chk("total_bytes", i, x.b, m_tot[i][0]);
      chk("total_good", i, x.g, m_tot[i][1]);
      chk("total_bad", i, x.r, m_tot[i][2]);
      chk("overflow", i, 64'(x.o), 64'(m_ov[i]));
      chk("snap_bytes", i, x.sb, m_snap[i][0]);
      chk("snap_good", i, x.sg, m_snap[i][1]);
      chk("snap_bad", i, x.sr, m_snap[i][2]);
      chk("snap_overflow", i, 64'(x.so), 64'(m_sov[i]));
      chk("snap_valid", i, 64'(x.sv), 64'(m_sv[i]));
    end
  endtask
  task automatic drive(input logic v, input logic en, input logic [16:0] l, input logic g);
    valid = v; enable = en; len = l; good = g;
  endtask
  typedef struct {
    logic v, en;
    logic [16:0] l;
    logic g;
    logic [63:0] eb, eg, er;
  } vec_t;
  vec_t tbl[10];
  initial begin
    obs_t x;
    tbl[0] = '{1'b1, 1'b1, 17'd64, 1'b1, 64'd0, 64'd0, 64'd0};
    tbl[1] = '{1'b1, 1'b1, 17'd1518, 1'b1, 64'd64, 64'd1, 64'd0};
    tbl[2] = '{1'b1, 1'b1, 17'd9000, 1'b1, 64'd1582, 64'd2, 64'd0};
    tbl[3] = '{1'b0, 1'b1, 17'd0, 1'b0, 64'd10582, 64'd3, 64'd0};
    tbl[4] = '{1'b0, 1'b1, 17'd0, 1'b0, 64'd10582, 64'd3, 64'd0};
    tbl[5] = '{1'b1, 1'b0, 17'd100, 1'b0, 64'd10582, 64'd3, 64'd0};
    tbl[6] = '{1'b0, 1'b0, 17'd0, 1'b0, 64'd10582, 64'd3, 64'd0};
    tbl[7] = '{1'b1, 1'b1, 17'd200, 1'b1, 64'd10582, 64'd3, 64'd0};
    tbl[8] = '{1'b0, 1'b0, 17'd0, 1'b0, 64'd10782, 64'd4, 64'd0};
    tbl[9] = '{1'b0, 1'b0, 17'd0, 1'b0, 64'd10782, 64'd4, 64'd0};
    rst = 1'b1; snap_req = 1'b0; snap_clear = 1'b0;
    drive(1'b0, 1'b0, 17'd0, 1'b0);
    step();
    x = get(0);
    chk("reset_bytes", 0, x.b, 64'd0);
    chk("reset_snap_valid", 0, 64'(x.sv), 64'd0);
    rst = 1'b0;
    for (int t = 0; t < 10; t++) begin
      drive(tbl[t].v, tbl[t].en, tbl[t].l, tbl[t].g);
      step();
      x = get(0);
      chk("tbl_bytes", t, x.b, tbl[t].eb);
      chk("tbl_good", t, x.g, tbl[t].eg);
      chk("tbl_bad", t, x.r, tbl[t].er);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b1, 1'b1, 17'd250, 1'b1);
    step();
    drive(1'b1, 1'b1, 17'd10, 1'b1);
    step();
    drive(1'b0, 1'b1, 17'd0, 1'b0);
    step();
    x = get(1);
    chk("wrap_bytes", 1, x.b, 64'd4);
    chk("wrap_ovf", 1, 64'(x.o), 64'd1);
    x = get(2);
    chk("sat_bytes", 2, x.b, 64'd255);
    chk("sat_ovf", 2, 64'(x.o), 64'd1);
    drive(1'b1, 1'b1, 17'd5, 1'b0);
    step();
    drive(1'b0, 1'b1, 17'd0, 1'b0);
    step();
    x = get(1);
    chk("wrap_bytes2", 1, x.b, 64'd9);
    chk("wrap_ovf_sticky", 1, 64'(x.o), 64'd1);
    x = get(2);
    chk("sat_hold", 2, x.b, 64'd255);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int t = 0; t < 5; t++) begin
      drive(1'b1, 1'b1, 17'd200, 1'b1);
      step();
    end
    drive(1'b1, 1'b1, 17'd60, 1'b0);
    step();
    x = get(0);
    chk("pre_snap_bytes", 0, x.b, 64'd1000);
    chk("pre_snap_good", 0, x.g, 64'd5);
    drive(1'b1, 1'b1, 17'd64, 1'b1);
    snap_req = 1'b1; snap_clear = 1'b1;
    step();
    x = get(0);
    chk("snap_bytes", 0, x.sb, 64'd1060);
    chk("snap_bad", 0, x.sr, 64'd1);
    chk("snap_good", 0, x.sg, 64'd5);
    chk("snap_valid", 0, 64'(x.sv), 64'd1);
    chk("cleared_bytes", 0, x.b, 64'd0);
    snap_req = 1'b0; snap_clear = 1'b0;
    drive(1'b0, 1'b1, 17'd0, 1'b0);
    step();
    x = get(0);
    chk("post_bytes", 0, x.b, 64'd64);
    chk("post_good", 0, x.g, 64'd1);
    chk("post_bad", 0, x.r, 64'd0);
    chk("snap_valid_drop", 0, 64'(x.sv), 64'd0);
    drive(1'b1, 1'b1, 17'd77, 1'b1);
    step();
    rst = 1'b1; snap_req = 1'b1;
    step();
    x = get(0);
    chk("rst_bytes", 0, x.b, 64'd0);
    chk("rst_snap_bytes", 0, x.sb, 64'd0);
    chk("rst_snap_valid", 0, 64'(x.sv), 64'd0);
    rst = 1'b0; snap_req = 1'b0;
    drive(1'b0, 1'b0, 17'd0, 1'b0);
    step();
    x = get(0);
    chk("rst_drop_frame", 0, x.b, 64'd0);
    chk("rst_drop_good", 0, x.g, 64'd0);
    for (int t = 0; t < 3000; t++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0), 17'($urandom_range(0, 131071)), 1'($urandom_range(0, 1)));
      snap_req = ($urandom_range(0, 9) == 0) || (t % 500 < 3);
      snap_clear = 1'($urandom_range(0, 1));
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
